// File: rtl/dmem_responder.sv
// MEM-stage data memory: single-cycle stores, fixed-latency loads that stall the pipeline,
// with lane select, load extension and misalignment detection.
package dmem_pkg;
   typedef enum logic [1:0] {
      MEM_NONE  = 2'd0,
      MEM_READ  = 2'd1,
      MEM_WRITE = 2'd2
   } memaccess_t;
endpackage

module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS  = 1024,
   parameter int READ_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  memaccess_t  memaccess_m,
   input  logic [2:0]  funct3_m,
   input  logic [31:0] addr_m,
   input  logic [31:0] wdata_m,
   output logic [31:0] rdata_m,
   output logic        rvalid_m,
   output logic        stall_m,
   output logic        misalign_m
);
   localparam int ADDR_BITS = $clog2(DEPTH_WORDS);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
   localparam logic [3:0] CNT_INIT = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;

   logic [31:0] mem [DEPTH_WORDS];

   logic [1:0]           state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] widx_q, widx_d;
   logic [1:0]           lane_q, lane_d;
   logic [2:0]           f3_q, f3_d;
   logic [31:0]          rdata_q, rdata_d;

   logic [ADDR_BITS-1:0] widx_in, rd_idx;
   logic [1:0]           rd_lane;
   logic [2:0]           rd_f3;
   logic                 misaligned, in_idle, accept, we, load_now;
   logic [3:0]           be;
   logic [31:0]          wlane;
   logic                 unused_addr;

   assign unused_addr = ^addr_m[31:ADDR_BITS+2];

   function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] lane,
                                          input logic [2:0] f3);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{lane, 3'b000} +: 8];
      h = lane[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  extend = {{24{b[7]}}, b};
         3'b100:  extend = {24'd0, b};
         3'b001:  extend = {{16{h[15]}}, h};
         3'b101:  extend = {16'd0, h};
         default: extend = w;
      endcase
   endfunction

   always_comb begin
      widx_in    = addr_m[ADDR_BITS+1:2];
      // funct3[1:0]: 00 byte, 01 half, 1x word (undefined encodings act as word)
      misaligned = ((funct3_m[1:0] == 2'b01) && addr_m[0]) ||
                   (funct3_m[1] && (addr_m[1:0] != 2'b00));
      in_idle    = !reset && (state_q == IDLE);
      misalign_m = in_idle && (memaccess_m == MEM_READ || memaccess_m == MEM_WRITE) && misaligned;
      accept     = in_idle && (memaccess_m == MEM_READ) && !misaligned;
      we         = in_idle && (memaccess_m == MEM_WRITE) && !misaligned;
      stall_m    = accept || (!reset && (state_q == WAIT));
      rvalid_m   = !reset && (state_q == RESP);
      rdata_m    = rdata_q;

      case (funct3_m[1:0])
         2'b00: begin
            be    = 4'b0001 << addr_m[1:0];
            wlane = {4{wdata_m[7:0]}};
         end
         2'b01: begin
            be    = addr_m[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata_m[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wlane = wdata_m;
         end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      widx_d   = widx_q;
      lane_d   = lane_q;
      f3_d     = f3_q;
      load_now = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               widx_d = widx_in;
               lane_d = addr_m[1:0];
               f3_d   = funct3_m;
               if (READ_LATENCY == 1) begin
                  state_d  = RESP;
                  load_now = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d  = RESP;
               load_now = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Single-cycle latency reads straight from the request, before anything is latched
      rd_idx  = (state_q == IDLE) ? widx_in : widx_q;
      rd_lane = (state_q == IDLE) ? addr_m[1:0] : lane_q;
      rd_f3   = (state_q == IDLE) ? funct3_m : f3_q;
      rdata_d = load_now ? extend(mem[rd_idx], rd_lane, rd_f3) : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         widx_q  <= '0;
         lane_q  <= 2'd0;
         f3_q    <= 3'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         widx_q  <= widx_d;
         lane_q  <= lane_d;
         f3_q    <= f3_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[widx_in][b*8 +: 8] <= wlane[b*8 +: 8];
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table of loads/stores with a queue of expected load data,
// plus hand-written reset/abort sequences.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   memaccess_t  memaccess_m;
   logic [2:0]  funct3_m;
   logic [31:0] addr_m, wdata_m, rdata_m;
   logic        rvalid_m, stall_m, misalign_m;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      memaccess_t  acc;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        mis;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[$];

   dmem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .memaccess_m(memaccess_m), .funct3_m(funct3_m),
      .addr_m(addr_m), .wdata_m(wdata_m), .rdata_m(rdata_m), .rvalid_m(rvalid_m),
      .stall_m(stall_m), .misalign_m(misalign_m)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input memaccess_t a, input logic [2:0] f, input logic [31:0] ad,
                        input logic [31:0] wd);
      memaccess_m = a;
      funct3_m    = f;
      addr_m      = ad;
      wdata_m     = wd;
   endtask

   function automatic vec_t mk(input memaccess_t a, input logic [2:0] f, input logic [31:0] ad,
                               input logic [31:0] wd, input logic m, input logic [31:0] e);
      vec_t v;
      v.acc = a; v.f3 = f; v.addr = ad; v.wdata = wd; v.mis = m; v.exp = e;
      return v;
   endfunction

   // All tasks start and end at posedge+1
   task automatic do_store(input string name, input vec_t v);
      drive(v.acc, v.f3, v.addr, v.wdata);
      #1;
      chk({name, " st_stall"}, 32'(stall_m), 32'd0);
      chk({name, " st_mis"}, 32'(misalign_m), 32'd0);
      @(posedge clk); #1;
      memaccess_m = MEM_NONE;
   endtask

   task automatic do_mis(input string name, input vec_t v);
      drive(v.acc, v.f3, v.addr, v.wdata);
      #1;
      chk({name, " mis"}, 32'(misalign_m), 32'd1);
      chk({name, " mis_stall"}, 32'(stall_m), 32'd0);
      @(posedge clk); #1;
      chk({name, " mis_rvalid"}, 32'(rvalid_m), 32'd0);
      memaccess_m = MEM_NONE;
   endtask

   task automatic do_load(input string name, input logic [2:0] f, input logic [31:0] ad,
                          input logic [31:0] e);
      int  stalls;
      int  cyc;
      bit  got;
      drive(MEM_READ, f, ad, 32'h0);
      exp_q.push_back(e);
      stalls = 0;
      cyc    = 0;
      got    = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         #1;
         if (rvalid_m) begin
            got = 1;
            cyc = c;
            chk({name, " stall_at_resp"}, 32'(stall_m), 32'd0);
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL %s: rvalid with empty scoreboard", name);
            end else begin
               chk({name, " rdata"}, rdata_m, exp_q.pop_front());
            end
         end else if (stall_m) begin
            stalls++;
         end
         @(posedge clk); #1;
      end
      memaccess_m = MEM_NONE;
      if (!got) begin
         checks++; errors++;
         $display("FAIL %s: no rvalid within 20 cycles, got none expected data %h", name, e);
         void'(exp_q.pop_front());
      end else begin
         chk({name, " stall_cycles"}, 32'(stalls), 32'(LAT));
         chk({name, " latency"}, 32'(cyc), 32'(LAT));
      end
   endtask

   initial begin
      vecs.push_back(mk(MEM_WRITE, 3'b010, 32'h10,   32'h80FF7F01, 0, 0));
      vecs.push_back(mk(MEM_READ,  3'b010, 32'h10,   0, 0, 32'h80FF7F01));
      vecs.push_back(mk(MEM_READ,  3'b000, 32'h13,   0, 0, 32'hFFFFFF80));
      vecs.push_back(mk(MEM_READ,  3'b100, 32'h13,   0, 0, 32'h00000080));
      vecs.push_back(mk(MEM_READ,  3'b001, 32'h12,   0, 0, 32'hFFFF80FF));
      vecs.push_back(mk(MEM_READ,  3'b101, 32'h10,   0, 0, 32'h00007F01));
      vecs.push_back(mk(MEM_WRITE, 3'b000, 32'h11,   32'h123456AA, 0, 0));
      vecs.push_back(mk(MEM_READ,  3'b010, 32'h10,   0, 0, 32'h80FFAA01));
      vecs.push_back(mk(MEM_READ,  3'b010, 32'h12,   0, 1, 0));
      vecs.push_back(mk(MEM_WRITE, 3'b001, 32'h11,   32'h0000FFFF, 1, 0));
      vecs.push_back(mk(MEM_READ,  3'b101, 32'h13,   0, 1, 0));
      vecs.push_back(mk(MEM_WRITE, 3'b010, 32'h12,   32'hFFFFFFFF, 1, 0));
      vecs.push_back(mk(MEM_READ,  3'b010, 32'h10,   0, 0, 32'h80FFAA01));
      vecs.push_back(mk(MEM_READ,  3'b010, 32'h1010, 0, 0, 32'h80FFAA01));
      vecs.push_back(mk(MEM_WRITE, 3'b001, 32'h1012, 32'h5555BEEF, 0, 0));
      vecs.push_back(mk(MEM_READ,  3'b001, 32'h12,   0, 0, 32'hFFFFBEEF));
      vecs.push_back(mk(MEM_READ,  3'b000, 32'h10,   0, 0, 32'h00000001));
      vecs.push_back(mk(MEM_READ,  3'b000, 32'h11,   0, 0, 32'hFFFFFFAA));
      vecs.push_back(mk(MEM_WRITE, 3'b010, 32'h20,   32'h12345678, 0, 0));
      vecs.push_back(mk(MEM_READ,  3'b101, 32'h22,   0, 0, 32'h00001234));
      vecs.push_back(mk(MEM_READ,  3'b000, 32'h21,   0, 0, 32'h00000056));
      vecs.push_back(mk(MEM_READ,  3'b011, 32'h20,   0, 0, 32'h12345678));
      vecs.push_back(mk(MEM_WRITE, 3'b000, 32'h23,   32'h000000F0, 0, 0));
      vecs.push_back(mk(MEM_READ,  3'b100, 32'h23,   0, 0, 32'h000000F0));
      vecs.push_back(mk(MEM_READ,  3'b010, 32'h1020, 0, 0, 32'hF0345678));

      // Reset: idle outputs and requests ignored while reset is high
      reset = 1'b1;
      drive(MEM_NONE, 3'b010, 32'h0, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst rvalid", 32'(rvalid_m), 32'd0);
      chk("rst rdata", rdata_m, 32'd0);
      chk("rst stall", 32'(stall_m), 32'd0);
      drive(MEM_READ, 3'b010, 32'h10, 32'h0);
      #1;
      chk("rst load stall", 32'(stall_m), 32'd0);
      drive(MEM_READ, 3'b010, 32'h12, 32'h0);
      #1;
      chk("rst mis", 32'(misalign_m), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      drive(MEM_NONE, 3'b010, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("idle rvalid", 32'(rvalid_m), 32'd0);
         chk("idle stall", 32'(stall_m), 32'd0);
         chk("idle mis", 32'(misalign_m), 32'd0);
         @(posedge clk); #1;
      end

      // Non-access encoding with a misaligned address must do nothing
      drive(memaccess_t'(2'b11), 3'b010, 32'h12, 32'h0);
      #1;
      chk("noacc mis", 32'(misalign_m), 32'd0);
      chk("noacc stall", 32'(stall_m), 32'd0);
      @(posedge clk); #1;
      memaccess_m = MEM_NONE;

      for (int i = 0; i < vecs.size(); i++) begin
         string nm;
         nm = $sformatf("v%0d", i);
         if (vecs[i].mis) do_mis(nm, vecs[i]);
         else if (vecs[i].acc == MEM_WRITE) do_store(nm, vecs[i]);
         else do_load(nm, vecs[i].f3, vecs[i].addr, vecs[i].exp);
      end

      // rdata holds after rvalid falls
      #1;
      chk("hold rvalid", 32'(rvalid_m), 32'd0);
      chk("hold rdata", rdata_m, 32'hF0345678);
      @(posedge clk); #1;

      // Abort: reset one cycle into WAIT, then the held load is re-accepted
      drive(MEM_READ, 3'b010, 32'h10, 32'h0);
      #1;
      chk("abort accept stall", 32'(stall_m), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("abort stall", 32'(stall_m), 32'd0);
      chk("abort mis", 32'(misalign_m), 32'd0);
      chk("abort rvalid", 32'(rvalid_m), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      do_load("reaccept", 3'b010, 32'h10, 32'hBEEFAA01);

      // Store under reset must not write
      reset = 1'b1;
      drive(MEM_WRITE, 3'b010, 32'h10, 32'hDEADBEEF);
      #1;
      chk("rst store stall", 32'(stall_m), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      memaccess_m = MEM_NONE;
      do_load("after rst store", 3'b010, 32'h10, 32'hBEEFAA01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder at the MEM stage of the RISC-V pipeline; it serves the loads and stores the hazard logic reasons about. Stores complete in one cycle. Loads take a fixed, parameterised latency, during which the block raises a stall so the front of the pipeline holds the load in place. Byte/halfword lane selection, load sign/zero extension and misalignment detection are done here.

## Interface
- DEPTH_WORDS, 1024: memory depth in 32-bit words; power of two; ADDR_BITS = log2(DEPTH_WORDS).
- READ_LATENCY, 2: cycles from load acceptance to rvalid_m; legal range 1..15.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- memaccess_m  input  memaccess_t  MEM_READ = load, MEM_WRITE = store, any other value = no access.
- funct3_m  input  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_m  input  32  byte address.
- wdata_m  input  32  store data; low bytes used for B/H.
- rdata_m  output  32  extended load data; valid while rvalid_m = 1.
- rvalid_m  output  1  one-cycle load-complete strobe.
- stall_m  output  1  hold pipeline; combinational.
- misalign_m  output  1  misaligned request present; combinational.

## Operation
- States: IDLE, WAIT, RESP. Counter cnt is 4 bits.
- Word index = addr_m[ADDR_BITS+1:2]. Upper address bits are ignored, so addresses wrap.
- Misaligned cases:
  - H/HU/SH with addr_m[0] = 1.
  - W/SW with addr_m[1:0] != 0.
- Misaligned request in IDLE:
  - misalign_m = 1 and stall_m = 0.
  - No write occurs, no state change, rvalid_m is not asserted.
- Aligned store in IDLE: the memory is updated at the clock edge.
  - SB: byte lane addr_m[1:0].
  - SH: halfword lane addr_m[1].
  - SW: full word.
  - stall_m = 0.
- Aligned load in IDLE:
  - The request is accepted; word index, lane and funct3 are latched.
  - stall_m = 1 in the accept cycle.
  - READ_LATENCY = 1: next state is RESP.
  - READ_LATENCY > 1: next state is WAIT with cnt = READ_LATENCY-2.
- WAIT:
  - stall_m = 1.
  - cnt decrements each cycle; at cnt = 0 the next state is RESP.
  - The memory word is read into an internal register on the WAIT→RESP or IDLE→RESP edge.
- RESP:
  - rvalid_m = 1, stall_m = 0, rdata_m holds the extended data.
  - Next state is IDLE unconditionally.
  - The still-present load is not re-accepted in RESP.
- Requests arriving in WAIT or RESP are ignored; no write occurs.
- Load extension, using the latched lane:
  - B: sign-extend bit 7.
  - BU: zero-extend.
  - H: sign-extend bit 15.
  - HU: zero-extend.
  - W: pass-through.
  - Undefined funct3 behaves as W.
- Memory contents are not reset and are not initialised.

## Timing
- Reset values: state IDLE, cnt 0, rdata_m 0, rvalid_m 0.
- While reset = 1, stall_m = 0 and misalign_m = 0, and no write occurs.
- Load latency: an accept at cycle N gives rvalid_m at cycle N+READ_LATENCY.
- stall_m is high for exactly READ_LATENCY cycles per load.
- Back-to-back loads are legal: a new load can be accepted in the cycle after RESP, so throughput is one load per READ_LATENCY+1 cycles.
- Reset asserted in WAIT or RESP:
  - The load is abandoned and no rvalid_m is produced.
  - If the load is still presented after reset falls, it is re-accepted as new.
- A store followed immediately by a load to the same word returns the new data.
- rdata_m holds its last value after rvalid_m falls; consumers qualify it with rvalid_m.

## Test plan
- Reset, idle (READ_LATENCY = 2): all outputs 0 throughout.
- SW 0x80FF7F01 @0x10, then LW @0x10:
  - stall_m is high for 2 cycles.
  - rvalid_m pulses at accept+2 with rdata_m = 0x80FF7F01.
- Same word, byte and half loads:
  - LB @0x13 → 0xFFFFFF80.
  - LBU @0x13 → 0x00000080.
  - LH @0x12 → 0xFFFF80FF.
  - LHU @0x10 → 0x00007F01.
- SB 0xAA @0x11 over 0x80FF7F01, then LW @0x10 → 0x80FFAA01.
- LW @0x12 and SH @0x11:
  - misalign_m = 1, stall_m = 0.
  - Memory is unchanged (re-read LW @0x10 matches).
- Abort and aliasing:
  - Assert reset one cycle into WAIT: no rvalid_m, stall_m = 0 during reset; the load re-presented after reset completes normally.
  - DEPTH_WORDS = 1024: address 0x1010 aliases 0x10.
